// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Holds the receiver state encoding and the default bit period.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 868;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 1 (idle line).
// Latency two clocks; no flow control.
module sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: byte appears one cycle after the mid-stop sample.
// Holds one byte; a new byte arriving while that one is unconsumed is dropped with an overrun pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rready,
    output logic       ferr,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    logic rxd_s;

    rx_state_e     state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [2:0]    idx_q,     idx_d;
    logic [7:0]    shift_q,   shift_d;
    logic [7:0]    rdata_q,   rdata_d;
    logic          rvalid_q,  rvalid_d;
    logic          ferr_q,    ferr_d;
    logic          overrun_q, overrun_d;
    logic          expire;

    sync2 u_sync2 (
        .clk  (clk),
        .rstn (rstn),
        .d    (rxd),
        .q    (rxd_s)
    );

    assign expire = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q & ~rready;
        ferr_d    = 1'b0;
        overrun_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (!expire) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxd_s) begin
                    cnt_d   = FULL_LOAD;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!expire) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d[idx_q] = rxd_s;
                    cnt_d          = FULL_LOAD;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (!expire) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxd_s) begin
                    // A transfer in this same cycle frees the slot for the new byte.
                    if (!rvalid_q || rready) begin
                        rdata_d  = shift_q;
                        rvalid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // Parks here through a break so it is not read as a run of 0x00 bytes.
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign ferr    = ferr_q;
    assign overrun = overrun_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal values are 4 or more, even.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 rxd  input  1  serial line; asynchronous to clk; idle high; 8N1 framing, LSB first.
REQ-005 rdata  output  8  received byte; stable while rvalid=1.
REQ-006 rvalid  output  1  rdata holds an unconsumed byte.
REQ-007 rready  input  1  consumer accepts; transfer occurs on a cycle with rvalid=1 and rready=1.
REQ-008 ferr  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-cycle pulse: byte completed while the previous byte was still unconsumed.

Function
REQ-010 rxd shall pass through a 2-flop synchronizer; all later logic sees only the synchronized value rxd_s.
REQ-011 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-012 IDLE: on rxd_s=0, load bit counter with CLKS_PER_BIT/2-1 and go to START.
REQ-013 START: at counter expiry, sample rxd_s; if 0, load CLKS_PER_BIT-1, clear bit index, go to DATA; if 1 (glitch), return to IDLE with no output.
REQ-014 DATA: at each expiry, shift rxd_s into bit[index] (LSB first) and reload CLKS_PER_BIT-1; after index 7, go to STOP.
REQ-015 STOP: at expiry, sample rxd_s; if 1, deliver the byte per REQ-017 and go to IDLE; if 0, pulse ferr, discard the byte, go to WAIT_IDLE.
REQ-016 WAIT_IDLE: remain until rxd_s=1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 bytes.
REQ-017 Delivery timing: rdata/rvalid update on the cycle after the stop sample; the stop sample is CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after IDLE detects rxd_s=0.
REQ-018 Delivery with rvalid=0, or with rvalid=1 and rready=1 in the same cycle: load rdata with the new byte and keep rvalid=1.
REQ-019 Delivery with rvalid=1 and rready=0: keep the old rdata and rvalid; drop the new byte; pulse overrun.
REQ-020 rvalid shall clear on the cycle after a transfer, unless REQ-018 applies in that cycle.
REQ-021 rvalid shall never deassert without a transfer; rdata shall not change while rvalid=1 and rready=0.
REQ-022 ferr and overrun shall not both assert in the same cycle.
REQ-023 Reception proceeds independently of rready; back-pressure only affects REQ-019.

Reset
REQ-024 rstn=0 shall immediately force: FSM to IDLE; counter, bit index and shift register to 0; synchronizer flops to 1; rdata=0x00; rvalid=0; ferr=0; overrun=0.
REQ-025 A reset mid-frame abandons the frame with no output.
REQ-026 After reset release, the receiver rearms only on a falling rxd_s. A line already low at release is treated as a start edge and validated per REQ-013.

Structure
REQ-027 Package uart_pkg shall hold the FSM state enum typedef and the default CLKS_PER_BIT constant; uart_rx imports it.
REQ-028 One sub-module, sync2: a 2-flop synchronizer with async active-low reset and reset value 1. The existing synchronous-reset flop shall not be reused for this.
REQ-029 The counter width is $clog2(CLKS_PER_BIT); there is no other arithmetic.

Verification (bench uses CLKS_PER_BIT=16)
REQ-030 Send 0xA5 with rready=1 -> rvalid rises exactly 155 cycles after rxd falls (2 sync + 8 + 144 + 1), rdata=0xA5, one-cycle rvalid, ferr=0.
REQ-031 Send 0x3C then 0x81 with rready=0 -> rdata stays 0x3C, overrun pulses once at the second stop sample; raising rready then empties, rvalid=0.
REQ-032 Drive rxd low for 4 cycles in idle -> glitch rejected; rvalid, ferr and overrun stay 0; FSM back in IDLE.
REQ-033 Send 0x55 with stop bit held low for 40 cycles -> ferr pulses once, no rvalid, no second frame decoded until rxd returns high.
REQ-034 Assert rstn=0 during data bit 4 of 0xF0 -> all outputs 0 that cycle; next clean 0x0F frame received as 0x0F.
REQ-035 Hold rready=1 with a pending byte at the cycle the next byte delivers -> rvalid stays 1, rdata switches to the new byte, no overrun.
